// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scanner with anode dead-time.
// Frames are double-buffered so the lit frame only changes at a scan boundary.
module seg_scan_driver #(
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  seg_out,
  output logic [7:0]  an_out,
  output logic        scan_done
);

  localparam int unsigned PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [7:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]    AN_OFF    = AN_ACTIVE_LOW  ? 8'hFF : 8'h00;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_digit;
  logic [63:0]   r_active;
  logic [63:0]   r_pending;
  logic          r_ready;
  logic          r_scan_done;
  logic [7:0]    r_seg;
  logic [7:0]    r_an;

  logic          w_tick;
  logic          w_boundary;
  logic          w_accept;
  logic [7:0]    w_byte;
  logic [7:0]    w_sel;
  logic [7:0]    w_seg_nxt;
  logic [7:0]    w_an_nxt;

  assign w_tick     = (r_presc == TICK_MAX);
  assign w_boundary = w_tick && (r_digit == 3'd7);
  assign w_accept   = frame_valid && r_ready;
  assign w_byte     = r_active[{r_digit, 3'b000} +: 8];
  assign w_sel      = 8'b0000_0001 << r_digit;

  // Segment/anode drive for the current digit; dead-time and empty slots stay dark.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_an_nxt  = AN_OFF;
    if ((r_presc >= BLANK_END) && (w_byte != 8'h00)) begin
      w_seg_nxt = SEG_ACTIVE_LOW ? ~w_byte : w_byte;
      w_an_nxt  = AN_ACTIVE_LOW  ? ~w_sel  : w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_digit     <= 3'd0;
      r_active    <= 64'h0;
      r_pending   <= 64'h0;
      r_ready     <= 1'b1;
      r_scan_done <= 1'b0;
      r_seg       <= SEG_OFF;
      r_an        <= AN_OFF;
    end else begin
      r_presc     <= w_tick ? '0 : r_presc + PW'(1);
      r_scan_done <= w_boundary;
      r_seg       <= w_seg_nxt;
      r_an        <= w_an_nxt;
      if (w_tick) begin
        r_digit <= r_digit + 3'd1;
      end
      // Accept needs an empty slot and a swap needs a full one, so they never coincide.
      if (w_accept) begin
        r_pending <= frame_in;
        r_ready   <= 1'b0;
      end else if (w_boundary && !r_ready) begin
        r_active <= r_pending;
        r_ready  <= 1'b1;
      end
    end
  end

  assign frame_ready = r_ready;
  assign seg_out     = r_seg;
  assign an_out      = r_an;
  assign scan_done   = r_scan_done;

endmodule
